// File: rtl/ifu_hs.sv
// Multi-cycle instruction fetch unit: one outstanding imem request, a single
// buffered instruction toward decode, redirects with stale-response dropping.
//   state   | meaning
//   IDLE    | first cycle after reset
//   REQ     | request presented to imem
//   WAIT    | waiting for response (park=1: misaligned target, wait for redirect)
//   HOLD    | instruction offered to decode
//   HALTED  | fetch stopped until reset
module ifu_hs #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h8000_0000),
    parameter bit              ALIGN_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [1:0]      inst_err,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    input  logic            halt,
    output logic [XLEN-1:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALTED
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            park_q, park_d;
    logic            hpend_q, hpend_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [1:0]      inst_err_q, inst_err_d;
    logic            mis;

    assign mis            = ALIGN_CHECK && (redir_pc[1:0] != 2'b00);
    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == S_HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_err       = inst_err_q;
    assign pc             = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            park_q     <= 1'b0;
            hpend_q    <= 1'b0;
            inst_q     <= 32'h0;
            inst_pc_q  <= '0;
            inst_err_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            park_q     <= park_d;
            hpend_q    <= hpend_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            inst_err_q <= inst_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        park_d     = park_q;
        hpend_d    = hpend_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_err_d = inst_err_q;

        // A misaligned redirect leaves WAIT early, so the dropped response can land anywhere.
        if (imem_resp_valid && drop_q && !(state_q == S_WAIT && !park_q))
            drop_d = 1'b0;

        case (state_q)
            S_IDLE: state_d = halt ? S_HALTED : S_REQ;

            S_REQ: begin
                if (halt) begin
                    if (imem_req_ready) begin
                        drop_d  = 1'b1;
                        hpend_d = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_HALTED;
                    end
                end else begin
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                        if (redir_valid) drop_d = 1'b1;
                    end
                    if (redir_valid) begin
                        pc_d = redir_pc;
                        if (mis) begin
                            inst_d     = 32'h0;
                            inst_pc_d  = redir_pc;
                            inst_err_d = 2'b10;
                            state_d    = S_HOLD;
                        end
                    end
                end
            end

            S_WAIT: begin
                if (park_q) begin
                    if (halt) begin
                        state_d = S_HALTED;
                    end else if (redir_valid) begin
                        pc_d   = redir_pc;
                        park_d = 1'b0;
                        if (mis) begin
                            inst_d     = 32'h0;
                            inst_pc_d  = redir_pc;
                            inst_err_d = 2'b10;
                            state_d    = S_HOLD;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end else if (halt || hpend_q) begin
                    if (imem_resp_valid) begin
                        drop_d  = 1'b0;
                        hpend_d = 1'b0;
                        state_d = S_HALTED;
                    end else begin
                        drop_d  = 1'b1;
                        hpend_d = 1'b1;
                    end
                end else if (redir_valid) begin
                    pc_d   = redir_pc;
                    drop_d = !imem_resp_valid;
                    if (mis) begin
                        inst_d     = 32'h0;
                        inst_pc_d  = redir_pc;
                        inst_err_d = 2'b10;
                        state_d    = S_HOLD;
                    end else if (imem_resp_valid) begin
                        state_d = S_REQ;
                    end
                end else if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d     = imem_resp_data;
                        inst_pc_d  = pc_q;
                        inst_err_d = {1'b0, imem_resp_err};
                        state_d    = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else if (redir_valid) begin
                    pc_d = redir_pc;
                    if (mis) begin
                        inst_d     = 32'h0;
                        inst_pc_d  = redir_pc;
                        inst_err_d = 2'b10;
                    end else begin
                        state_d = S_REQ;
                    end
                end else if (inst_ready) begin
                    pc_d = pc_q + XLEN'(4);
                    if (inst_err_q == 2'b10) begin
                        park_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end

            S_HALTED: state_d = S_HALTED;

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ifu_hs.sv
// Bench for ifu_hs: directed scenarios plus a randomized phase checked against
// a transaction-level model of the expected instruction stream.
module tb_ifu_hs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_err;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        halt;
    logic [31:0] pc;

    ifu_hs dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_err(inst_err), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .halt(halt), .pc(pc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // memory responder state
    bit          busy;
    int          cnt;
    logic [31:0] raddr;
    bit          fixed;
    int          fixed_lat;
    bit          last_acc;
    logic [31:0] last_addr;

    // reference model: pc of the next instruction decode should see
    logic [31:0] m_pc;
    bit          m_mis, m_park, m_halt, m_started;

    function automatic logic [31:0] memd(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        if (a == 32'h8000_000C) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic meme(input logic [31:0] a);
        logic [4:0] w;
        w = a[6:2];
        return (w == 5'd2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic reset_model();
        m_pc = 32'h8000_0000;
        m_mis = 0; m_park = 0; m_halt = 0; m_started = 0;
    endtask

    task automatic mem_reset();
        busy = 0; cnt = 0;
        imem_resp_valid = 0; imem_resp_data = 32'h0; imem_resp_err = 0;
        imem_req_ready = 1;
    endtask

    task automatic cyc();
        logic acc, hs;
        @(negedge clk);
        acc = imem_req_valid && imem_req_ready;
        hs  = inst_valid && inst_ready;
        last_acc  = acc;
        last_addr = imem_req_addr;
        if (rst_n) begin
            check("pc", pc, m_pc);
            if (m_park || m_halt) check("no_req", 32'(imem_req_valid), 32'd0);
            if (m_halt || (m_park && !m_mis)) check("no_inst", 32'(inst_valid), 32'd0);
            if (acc && !m_park) check("req_addr", imem_req_addr, m_pc);
            if (hs && !halt) begin
                check("inst_pc", inst_pc, m_pc);
                check("inst", inst, m_mis ? 32'd0 : memd(m_pc));
                check("inst_err", 32'(inst_err), m_mis ? 32'd2 : 32'(meme(m_pc)));
                m_pc = m_pc + 32'd4;
                m_mis = 0;
            end
            if (halt) m_halt = 1;
            else if (redir_valid && !m_halt && m_started) begin
                m_pc   = redir_pc;
                m_mis  = (redir_pc[1:0] != 2'b00);
                m_park = m_mis;
            end
            m_started = 1;
        end
        if (acc) begin
            busy  = 1;
            cnt   = fixed ? fixed_lat : int'($urandom_range(0, 3));
            raddr = imem_req_addr;
        end
        @(posedge clk);
        #1;
        imem_resp_valid = 0;
        imem_resp_data  = $urandom;
        imem_resp_err   = 1'($urandom_range(0, 1));
        if (busy) begin
            if (cnt == 0) begin
                imem_resp_valid = 1;
                imem_resp_data  = memd(raddr);
                imem_resp_err   = meme(raddr);
                busy = 0;
            end else begin
                cnt--;
            end
        end
        imem_req_ready = !busy && (fixed || $urandom_range(0, 3) != 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int r;
        rst_n = 0; inst_ready = 0; redir_valid = 0; redir_pc = 32'h0; halt = 0;
        fixed = 1; fixed_lat = 0;
        reset_model(); mem_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_err", 32'(inst_err), 32'd0);
        rst_n = 1; inst_ready = 1;

        // first fetch with a 1-cycle memory
        cyc();
        check("c1_req_valid", 32'(imem_req_valid), 32'd1);
        check("c1_req_addr", imem_req_addr, 32'h8000_0000);
        cyc(); cyc();
        check("c3_inst_valid", 32'(inst_valid), 32'd1);
        check("c3_inst_pc", inst_pc, 32'h8000_0000);
        check("c3_inst", inst, 32'h0000_0413);
        cyc();
        check("c4_req_addr", imem_req_addr, 32'h8000_0004);

        // decode backpressure in HOLD
        inst_ready = 0;
        cyc(); cyc();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(inst_valid), 32'd1);
            check("stall_inst_pc", inst_pc, 32'h8000_0004);
            check("stall_inst", inst, memd(32'h8000_0004));
            check("stall_no_req", 32'(imem_req_valid), 32'd0);
            cyc();
        end
        inst_ready = 1;
        cyc();
        check("after_stall_req", 32'(imem_req_valid), 32'd1);
        check("after_stall_addr", imem_req_addr, 32'h8000_0008);

        // access fault response
        cyc(); cyc();
        check("fault_err", 32'(inst_err), 32'd1);
        check("fault_pc", inst_pc, 32'h8000_0008);
        cyc();

        // redirect while waiting; the late response must be dropped
        fixed_lat = 2;
        cyc();
        redir_valid = 1; redir_pc = 32'h8000_0100;
        cyc();
        redir_valid = 0; fixed_lat = 0;
        n = 0;
        while (!imem_req_valid && n < 12) begin
            check("stale_hidden", 32'(inst_valid), 32'd0);
            cyc();
            n++;
        end
        check("redir_req", 32'(imem_req_valid), 32'd1);
        check("redir_addr", imem_req_addr, 32'h8000_0100);
        cyc(); cyc();
        check("redir_inst_pc", inst_pc, 32'h8000_0100);

        // misaligned redirect from HOLD
        inst_ready = 0; redir_valid = 1; redir_pc = 32'h8000_0102;
        cyc();
        redir_valid = 0;
        check("mis_valid", 32'(inst_valid), 32'd1);
        check("mis_err", 32'(inst_err), 32'd2);
        check("mis_pc", inst_pc, 32'h8000_0102);
        check("mis_inst", inst, 32'h0);
        check("mis_no_req", 32'(imem_req_valid), 32'd0);
        inst_ready = 1;
        cyc();
        for (int i = 0; i < 6; i++) begin
            check("park_no_req", 32'(imem_req_valid), 32'd0);
            cyc();
        end
        redir_valid = 1; redir_pc = 32'h8000_0200;
        cyc();
        redir_valid = 0;
        check("unpark_req", 32'(imem_req_valid), 32'd1);
        check("unpark_addr", imem_req_addr, 32'h8000_0200);

        // randomized traffic
        fixed = 0;
        for (int i = 0; i < 2000; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                r = int'($urandom_range(0, 7));
                redir_valid = 1;
                if (r == 0) redir_pc = 32'hFFFF_FFFC;
                else redir_pc = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 32'd4
                                + ((r == 1) ? 32'($urandom_range(1, 3)) : 32'd0);
            end else begin
                redir_valid = 0;
            end
            cyc();
        end
        redir_valid = 0; inst_ready = 1;

        // halt while a fetch is outstanding
        fixed = 1; fixed_lat = 2;
        redir_valid = 1; redir_pc = 32'h8000_0300;
        cyc();
        redir_valid = 0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!(last_acc && last_addr == 32'h8000_0300) && n < 60);
        check("halt_setup_addr", last_addr, 32'h8000_0300);
        halt = 1;
        cyc();
        halt = 0;
        for (int i = 0; i < 8; i++) begin
            redir_valid = (i == 3);
            redir_pc = 32'h8000_0400;
            check("halt_no_req", 32'(imem_req_valid), 32'd0);
            check("halt_no_inst", 32'(inst_valid), 32'd0);
            cyc();
        end
        redir_valid = 0;

        // reset recovery, then async reset in HOLD
        rst_n = 0;
        reset_model(); mem_reset(); fixed_lat = 0;
        @(posedge clk);
        #1;
        rst_n = 1; inst_ready = 0;
        cyc(); cyc(); cyc();
        check("hold_before_rst", 32'(inst_valid), 32'd1);
        check("hold_before_rst_pc", inst_pc, 32'h8000_0000);
        #2;
        rst_n = 0;
        #1;
        check("async_rst_valid", 32'(inst_valid), 32'd0);
        check("async_rst_pc", pc, 32'h8000_0000);
        reset_model(); mem_reset();
        @(posedge clk);
        #1;
        rst_n = 1; inst_ready = 1;
        cyc();
        check("restart_req", 32'(imem_req_valid), 32'd1);
        check("restart_addr", imem_req_addr, 32'h8000_0000);
        repeat (10) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
